// File: rtl/uart_controller_if.sv
// Host-side bus of the UART controller: TX push, RX pop, received byte and RX-ready interrupt.
interface uart_controller_if;
  logic [7:0] data_in;
  logic       write_nic;
  logic       read_nic;
  logic [7:0] data_out;
  logic       read_nic_i;

  modport master (
    output data_in, write_nic, read_nic,
    input  data_out, read_nic_i
  );

  modport slave (
    input  data_in, write_nic, read_nic,
    output data_out, read_nic_i
  );
endinterface

// File: rtl/uart_controller.sv
// Full-duplex 8N1 UART controller: host-fed TX FIFO serialised on tx, and a framed,
// checked rx stream queued in an RX FIFO that the host pops.
module uart_controller #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_controller_if.slave host,
  input  logic             rx,
  output logic             tx
);
  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W   = PTR_W + 1;
  localparam int unsigned IDX_W     = $clog2(WORD_SIZE);

  localparam logic [CNT_W-1:0]   BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]   LAST_BIT = IDX_W'(WORD_SIZE - 1);
  localparam logic [LEVEL_W-1:0] FULL     = LEVEL_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // ---------------- TX FIFO ----------------
  logic [WORD_SIZE-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     tx_wr_ptr, tx_rd_ptr;
  logic [LEVEL_W-1:0]   tx_level;
  logic                 tx_push_c, tx_pop_c;

  assign tx_push_c = host.write_nic && (tx_level != FULL);

  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wr_ptr] <= host.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      tx_level <= tx_level + LEVEL_W'(tx_push_c) - LEVEL_W'(tx_pop_c);
    end
  end

  // ---------------- TX FSM ----------------
  logic [1:0]           tx_state, tx_state_n;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]     tx_idx, tx_idx_n;
  logic [WORD_SIZE-1:0] tx_shift, tx_shift_n;
  logic                 tx_line_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_pop_c   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (tx_level != '0) begin
          tx_pop_c   = 1'b1;
          tx_shift_n = tx_mem[tx_rd_ptr];
          tx_cnt_n   = '0;
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          if (tx_idx == LAST_BIT) tx_state_n = STOP;
          else                    tx_idx_n   = tx_idx + IDX_W'(1);
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit so queued frames leave back to back.
          if (tx_level != '0) begin
            tx_pop_c   = 1'b1;
            tx_shift_n = tx_mem[tx_rd_ptr];
            tx_state_n = START;
          end else begin
            tx_state_n = IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
    endcase
    tx_line_n = (tx_state_n == START) ? 1'b0 :
                (tx_state_n == DATA)  ? tx_shift_n[0] : 1'b1;
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic                 rx_meta, rx_sync;
  logic [1:0]           rx_state, rx_state_n;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
  logic [IDX_W-1:0]     rx_idx, rx_idx_n;
  logic [WORD_SIZE-1:0] rx_shift, rx_shift_n;
  logic                 rx_wait, rx_wait_n;
  logic                 rx_push_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_wait  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_wait  <= rx_wait_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_wait_n  = rx_wait;
    rx_push_c  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_sync) begin
          rx_cnt_n   = '0;
          rx_state_n = START;
        end
      end
      START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_sync ? IDLE : DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[WORD_SIZE-1:1]};
          if (rx_idx == LAST_BIT) rx_state_n = STOP;
          else                    rx_idx_n   = rx_idx + IDX_W'(1);
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // After a framing error, hold off until the line idles high again.
        if (rx_wait) begin
          if (rx_sync) begin
            rx_wait_n  = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_push_c  = 1'b1;
            rx_state_n = IDLE;
          end else begin
            rx_wait_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // ---------------- RX FIFO and host read port ----------------
  logic [WORD_SIZE-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rx_wr_ptr, rx_rd_ptr;
  logic [LEVEL_W-1:0]   rx_level, rx_level_nxt;
  logic                 rx_wr_c, rx_rd_c;

  assign rx_wr_c      = rx_push_c && (rx_level != FULL);
  assign rx_rd_c      = host.read_nic && (rx_level != '0);
  assign rx_level_nxt = rx_level + LEVEL_W'(rx_wr_c) - LEVEL_W'(rx_rd_c);

  always_ff @(posedge clk) begin
    if (rx_wr_c) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr       <= '0;
      rx_rd_ptr       <= '0;
      rx_level        <= '0;
      host.data_out   <= '0;
      host.read_nic_i <= 1'b0;
    end else begin
      if (rx_wr_c) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_rd_c) begin
        rx_rd_ptr     <= rx_rd_ptr + PTR_W'(1);
        host.data_out <= rx_mem[rx_rd_ptr];
      end
      rx_level        <= rx_level_nxt;
      host.read_nic_i <= (rx_level_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller: instance A feeds instance B over a serial link; a queue-based
// frame model predicts A.tx bit by bit and both RX FIFOs, checked every cycle.
module tb_uart_controller;
  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  localparam int DEPTH  = 8;
  localparam int FRAME  = 10 * CPB;
  // Start-bit cycle to byte visible: mid-stop sample, two synchroniser flops, one register.
  localparam int RX_LAT = 9 * CPB + HALF + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_drv = 1'b1;
  logic tx_a, tx_b;

  uart_controller_if host_a ();
  uart_controller_if host_b ();

  uart_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .host(host_a), .rx(rx_drv), .tx(tx_a));
  uart_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .host(host_b), .rx(tx_a), .tx(tx_b));

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned at;
    logic [7:0]      data;
  } ev_t;

  ev_t             ev_a[$], ev_b[$];
  logic [7:0]      txq[$], rxq_a[$], rxq_b[$], b_got[$];
  logic [7:0]      exp_dout_a = 8'h00, exp_dout_b = 8'h00;
  logic [7:0]      tx_byte = 8'h00;
  bit              tx_busy = 1'b0;
  int              tx_t = 0;
  longint unsigned cyc = 0;
  int              n_tests = 0, n_fail = 0;
  bit              auto_pop_b = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    logic [7:0] s;
    if (!tx_busy) return 1'b1;
    if (tx_t < CPB) return 1'b0;
    if (tx_t >= 9 * CPB) return 1'b1;
    s = tx_byte >> (tx_t / CPB - 1);
    return s[0];
  endfunction

  // Frame-level reference model, advanced once per clock edge.
  always @(posedge clk) begin
    int pre_tx, pre_a, pre_b;
    bit start;
    ev_t e;
    cyc++;
    if (!rst) begin
      txq.delete(); rxq_a.delete(); rxq_b.delete(); ev_a.delete(); ev_b.delete();
      tx_busy = 1'b0; tx_t = 0; exp_dout_a = 8'h00; exp_dout_b = 8'h00;
    end else begin
      pre_tx = txq.size();
      start  = 1'b0;
      if (tx_busy && tx_t != FRAME - 1) tx_t++;
      else if (pre_tx != 0) begin
        tx_byte = txq.pop_front(); tx_busy = 1'b1; tx_t = 0; start = 1'b1;
      end else tx_busy = 1'b0;
      if (start) begin
        e.at = cyc + 64'(RX_LAT); e.data = tx_byte; ev_b.push_back(e);
      end
      if (host_a.write_nic && pre_tx < DEPTH) txq.push_back(host_a.data_in);

      pre_a = rxq_a.size();
      if (host_a.read_nic && pre_a > 0) exp_dout_a = rxq_a.pop_front();
      if (ev_a.size() > 0 && ev_a[0].at == cyc) begin
        e = ev_a.pop_front();
        if (pre_a < DEPTH) rxq_a.push_back(e.data);
      end

      pre_b = rxq_b.size();
      if (host_b.read_nic && pre_b > 0) exp_dout_b = rxq_b.pop_front();
      if (ev_b.size() > 0 && ev_b[0].at == cyc) begin
        e = ev_b.pop_front();
        if (pre_b < DEPTH) rxq_b.push_back(e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("tx_a",   8'(tx_a), 8'(exp_tx()));
      check("tx_b",   8'(tx_b), 8'h01);
      check("irq_a",  8'(host_a.read_nic_i), 8'(rxq_a.size() != 0));
      check("irq_b",  8'(host_b.read_nic_i), 8'(rxq_b.size() != 0));
      check("dout_a", host_a.data_out, exp_dout_a);
      check("dout_b", host_b.data_out, exp_dout_b);
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    logic [9:0] bits;
    ev_t e;
    int g;
    bits = {stop_bit, b, 1'b0};
    if (stop_bit) begin
      e.at = cyc + 64'(RX_LAT); e.data = b; ev_a.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      tick(CPB);
    end
    rx_drv = 1'b1;
    g = (!stop_bit && gap < CPB) ? CPB : gap;
    tick(g);
  endtask

  task automatic glitch();
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(CPB);
  endtask

  task automatic write_a(input logic [7:0] b);
    host_a.data_in = b; host_a.write_nic = 1'b1;
    tick(1);
    host_a.write_nic = 1'b0;
  endtask

  task automatic pop_a();
    host_a.read_nic = 1'b1; tick(1); host_a.read_nic = 1'b0;
  endtask

  task automatic pop_b();
    host_b.read_nic = 1'b1; tick(1); host_b.read_nic = 1'b0;
  endtask

  // Drains B as frames arrive and records each popped byte.
  initial begin
    host_b.read_nic = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (auto_pop_b && rst && host_b.read_nic_i) begin
        host_b.read_nic = 1'b1;
        @(posedge clk); #2;
        host_b.read_nic = 1'b0;
        b_got.push_back(host_b.data_out);
      end
    end
  end

  initial begin
    logic [7:0] burst [14];
    host_a.data_in = 8'h00; host_a.write_nic = 1'b0; host_a.read_nic = 1'b0;
    host_b.data_in = 8'h00; host_b.write_nic = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_a",   8'(tx_a), 8'h01);
    check("reset_tx_b",   8'(tx_b), 8'h01);
    check("reset_irq_a",  8'(host_a.read_nic_i), 8'h00);
    check("reset_dout_a", host_a.data_out, 8'h00);
    rst = 1'b1;
    tick(5);

    // Single received frame
    send_frame(8'h55, 1'b1, 0);
    tick(2);
    check("single_irq", 8'(host_a.read_nic_i), 8'h01);
    pop_a();
    check("single_data", host_a.data_out, 8'h55);
    check("single_irq_clear", 8'(host_a.read_nic_i), 8'h00);

    // Framing error, then a good frame
    send_frame(8'hAA, 1'b0, CPB);
    check("ferr_irq", 8'(host_a.read_nic_i), 8'h00);
    send_frame(8'h3C, 1'b1, CPB);
    check("after_ferr_irq", 8'(host_a.read_nic_i), 8'h01);
    pop_a();
    check("after_ferr_data", host_a.data_out, 8'h3C);

    // Loopback A -> B: writes on cycles 0 and 3
    write_a(8'h55);
    tick(2);
    write_a(8'hAA);
    tick(25 * CPB);
    check("loop_irq", 8'(host_b.read_nic_i), 8'h01);
    pop_b();
    check("loop_first", host_b.data_out, 8'h55);
    pop_b();
    check("loop_second", host_b.data_out, 8'hAA);
    check("loop_irq_clear", 8'(host_b.read_nic_i), 8'h00);

    // Burst of 14 frames with gaps stepping by a quarter bit
    for (int k = 0; k < 14; k++) begin
      burst[k] = 8'($urandom);
      send_frame(burst[k], 1'b1, k * CPB / 4);
    end
    for (int k = 0; k < DEPTH; k++) begin
      pop_a();
      check("burst_data", host_a.data_out, burst[k]);
    end
    check("burst_empty", 8'(host_a.read_nic_i), 8'h00);
    send_frame(8'hC5, 1'b1, CPB);
    pop_a();
    check("burst_resync", host_a.data_out, 8'hC5);

    // TX FIFO overflow: one frame in flight, then nine back-to-back writes
    auto_pop_b = 1'b1;
    b_got.delete();
    write_a(8'hF0);
    tick(CPB);
    for (int i = 1; i <= 9; i++) begin
      host_a.data_in = 8'(i); host_a.write_nic = 1'b1;
      tick(1);
    end
    host_a.write_nic = 1'b0;
    tick(10 * FRAME);
    check("txfull_count", 8'(b_got.size()), 8'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < b_got.size()) check("txfull_data", b_got[i], (i == 0) ? 8'hF0 : 8'(i));
    end

    // Random full-duplex traffic
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r == 0) glitch();
          send_frame(8'($urandom), (r != 1), int'($urandom_range(0, 3 * CPB)));
        end
      end
      begin
        repeat (4000) begin
          @(posedge clk); #1;
          host_a.data_in   = 8'($urandom);
          host_a.write_nic = ($urandom_range(0, 39) == 0);
          host_a.read_nic  = ($urandom_range(0, 29) == 0);
        end
        host_a.write_nic = 1'b0;
        host_a.read_nic  = 1'b0;
      end
    join
    tick(10 * FRAME + 2 * CPB);
    for (int i = 0; i < 2 * DEPTH && host_a.read_nic_i; i++) pop_a();

    // Asynchronous reset in the middle of a TX frame
    write_a(8'hC3);
    tick(3 * CPB + 5);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_tx_a",   8'(tx_a), 8'h01);
    check("rst_irq_a",  8'(host_a.read_nic_i), 8'h00);
    check("rst_dout_a", host_a.data_out, 8'h00);
    @(posedge clk); #1;
    tick(3);
    rst = 1'b1;
    b_got.delete();
    tick(3);
    write_a(8'h5A);
    tick(FRAME + 2 * CPB);
    check("post_rst_count", 8'(b_got.size()), 8'd1);
    if (b_got.size() > 0) check("post_rst_data", b_got[0], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
